// File: rtl/rtc_adj_seq.sv
// rtc_adj_seq: bus master for the RTC register block. Serves single host
// accesses and turns each servo adjustment request into an uninterrupted
// burst of register writes (TICK_INC, NS_OFST, SC_OFST0/1, RTC_CTL).
// When the host and the servo request together, the winner alternates.
// A HOLD window follows every CTL write. During HOLD the host may use the bus,
// but a new sequence may not start.
module rtc_adj_seq #(
    parameter logic [23:0] RTC_BASE = 24'h000010,
    parameter logic [7:0]  CTL_OFS  = 8'h00,
    parameter logic [7:0]  TICK_OFS = 8'h04,
    parameter logic [7:0]  NSO_OFS  = 8'h08,
    parameter logic [7:0]  SCO0_OFS = 8'h0C,
    parameter logic [7:0]  SCO1_OFS = 8'h10,
    parameter int          HOLD_CYC = 4
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    input  logic        host_rd_i,
    input  logic        host_wr_i,
    output logic        host_ack_o,
    output logic [31:0] host_rdata_o,
    output logic        host_rvld_o,
    input  logic        adj_req_i,
    input  logic [2:0]  adj_mode_i,
    input  logic [31:0] adj_tick_inc_i,
    input  logic [31:0] adj_ns_i,
    input  logic [47:0] adj_sc_i,
    input  logic        cfg_intxms_sel_i,
    output logic        adj_busy_o,
    output logic        adj_done_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic        bus_rd_ce_o,
    output logic        bus_wr_ce_o,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [2:0] {
        IDLE, W_TICK, W_NS, W_SC0, W_SC1, W_CTL, HOLD, DONE
    } stateT;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    stateT       r_state;
    stateT       w_nextState;
    logic        w_hostReq;
    logic        w_hostGnt;
    logic        w_seqGnt;
    logic        r_rrPref;
    logic        r_modeOfs;
    logic        r_modeClr;
    logic        r_intx;
    logic [31:0] r_tick;
    logic [31:0] r_ns;
    logic [47:0] r_sc;
    logic [3:0]  r_holdCnt;
    logic [31:0] w_tickData;
    logic [31:0] w_nsData;
    logic        w_clrData;
    logic        w_intxData;

    // Work out which write a sequence opens with, from the mode bits.
    // The clear bit takes priority over the other two.
    function automatic stateT firstState(input logic [2:0] mode);
        if (mode[2])      return W_CTL;
        else if (mode[0]) return W_TICK;
        else if (mode[1]) return W_NS;
        else              return DONE;
    endfunction

    // The host request is ignored for one cycle after an ack.
    // This gives the host time to drop its level request.
    assign w_hostReq = (host_rd_i | host_wr_i) & ~host_ack_o;

    // The first write of a sequence is issued at the same edge that latches the
    // inputs, so it has to take its data straight from the ports.
    assign w_tickData = w_seqGnt ? adj_tick_inc_i   : r_tick;
    assign w_nsData   = w_seqGnt ? adj_ns_i         : r_ns;
    assign w_clrData  = w_seqGnt ? adj_mode_i[2]    : r_modeClr;
    assign w_intxData = w_seqGnt ? cfg_intxms_sel_i : r_intx;

    // Read data goes straight through from the slave's registered data, in the
    // cycle that follows the read strobe.
    assign host_rdata_o = host_rvld_o ? bus_rdata_i : 32'h0;

    // Next-state and arbitration: round-robin in IDLE, host-only in HOLD,
    // nothing while the atomic write burst is on the bus.
    always_comb begin
        w_nextState = r_state;
        w_hostGnt   = 1'b0;
        w_seqGnt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (adj_req_i && (!w_hostReq || r_rrPref)) begin
                    w_seqGnt    = 1'b1;
                    w_nextState = firstState(adj_mode_i);
                end else if (w_hostReq) begin
                    w_hostGnt = 1'b1;
                end
            end
            W_TICK:  w_nextState = r_modeOfs ? W_NS : DONE;
            W_NS:    w_nextState = W_SC0;
            W_SC0:   w_nextState = W_SC1;
            W_SC1:   w_nextState = W_CTL;
            W_CTL:   w_nextState = HOLD;
            HOLD: begin
                w_hostGnt = w_hostReq;
                if (r_holdCnt == HOLD_LAST) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register, input latches, and the registered bus/host/status outputs.
    // Outputs are driven from the state being entered, so each strobe lines up
    // with its W_* state.
    always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
        if (bus2ip_rst) begin
            r_state     <= IDLE;
            r_rrPref    <= 1'b0;
            r_modeOfs   <= 1'b0;
            r_modeClr   <= 1'b0;
            r_intx      <= 1'b0;
            r_tick      <= 32'h0;
            r_ns        <= 32'h0;
            r_sc        <= 48'h0;
            r_holdCnt   <= 4'h0;
            host_ack_o  <= 1'b0;
            host_rvld_o <= 1'b0;
            adj_busy_o  <= 1'b0;
            adj_done_o  <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_data_o  <= 32'h0;
            bus_rd_ce_o <= 1'b0;
            bus_wr_ce_o <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            host_ack_o  <= 1'b0;
            host_rvld_o <= bus_rd_ce_o;
            adj_done_o  <= (w_nextState == DONE);
            adj_busy_o  <= (w_nextState != IDLE) && (w_nextState != DONE);
            bus_addr_o  <= 32'h0;
            bus_data_o  <= 32'h0;
            bus_rd_ce_o <= 1'b0;
            bus_wr_ce_o <= 1'b0;

            if (w_hostGnt || w_seqGnt) begin
                r_rrPref <= ~r_rrPref;
            end

            if (w_seqGnt) begin
                r_modeOfs <= adj_mode_i[1];
                r_modeClr <= adj_mode_i[2];
                r_intx    <= cfg_intxms_sel_i;
                r_tick    <= adj_tick_inc_i;
                r_ns      <= adj_ns_i;
                r_sc      <= adj_sc_i;
            end

            if (w_nextState == HOLD && r_state != HOLD) begin
                r_holdCnt <= 4'h0;
            end else if (r_state == HOLD) begin
                r_holdCnt <= r_holdCnt + 4'd1;
            end

            if (w_hostGnt) begin
                host_ack_o  <= 1'b1;
                bus_rd_ce_o <= host_rd_i;
                bus_wr_ce_o <= host_wr_i;
                bus_addr_o  <= host_addr_i;
                bus_data_o  <= host_wr_i ? host_wdata_i : 32'h0;
            end else begin
                case (w_nextState)
                    W_TICK: begin
                        bus_wr_ce_o <= 1'b1;
                        bus_addr_o  <= {RTC_BASE, TICK_OFS};
                        bus_data_o  <= w_tickData;
                    end
                    W_NS: begin
                        bus_wr_ce_o <= 1'b1;
                        bus_addr_o  <= {RTC_BASE, NSO_OFS};
                        bus_data_o  <= w_nsData;
                    end
                    W_SC0: begin
                        bus_wr_ce_o <= 1'b1;
                        bus_addr_o  <= {RTC_BASE, SCO0_OFS};
                        bus_data_o  <= r_sc[47:16];
                    end
                    W_SC1: begin
                        bus_wr_ce_o <= 1'b1;
                        bus_addr_o  <= {RTC_BASE, SCO1_OFS};
                        bus_data_o  <= {16'h0, r_sc[15:0]};
                    end
                    W_CTL: begin
                        bus_wr_ce_o <= 1'b1;
                        bus_addr_o  <= {RTC_BASE, CTL_OFS};
                        bus_data_o  <= {29'h0, w_intxData, w_clrData, ~w_clrData};
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_adj_seq.sv
// tb_rtc_adj_seq: randomized and directed stimulus for rtc_adj_seq.
// A behavioural model builds the expected write list and timing for each sequence.
// A bus monitor collects what the DUT actually drove.
module tb_rtc_adj_seq;

    localparam int          HOLD     = 4;
    localparam logic [31:0] A_CTL    = 32'h0000_1000;
    localparam logic [31:0] A_TICK   = 32'h0000_1004;
    localparam logic [31:0] A_NS     = 32'h0000_1008;
    localparam logic [31:0] A_SC0    = 32'h0000_100C;
    localparam logic [31:0] A_SC1    = 32'h0000_1010;
    localparam logic [31:0] RD_XOR   = 32'h5A5A_F00F;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] host_addr_i, host_wdata_i, host_rdata_o;
    logic        host_rd_i, host_wr_i, host_ack_o, host_rvld_o;
    logic        adj_req_i, cfg_intxms_sel_i, adj_busy_o, adj_done_o;
    logic [2:0]  adj_mode_i;
    logic [31:0] adj_tick_inc_i, adj_ns_i;
    logic [47:0] adj_sc_i;
    logic [31:0] bus_addr_o, bus_data_o, bus_rdata_i;
    logic        bus_rd_ce_o, bus_wr_ce_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } recT;

    recT seqQ[$];
    recT expQ[$];
    int  hostCycQ[$];
    bit  expHasCtl;

    rtc_adj_seq dut (
        .bus2ip_clk       (clk),
        .bus2ip_rst       (rst),
        .host_addr_i      (host_addr_i),
        .host_wdata_i     (host_wdata_i),
        .host_rd_i        (host_rd_i),
        .host_wr_i        (host_wr_i),
        .host_ack_o       (host_ack_o),
        .host_rdata_o     (host_rdata_o),
        .host_rvld_o      (host_rvld_o),
        .adj_req_i        (adj_req_i),
        .adj_mode_i       (adj_mode_i),
        .adj_tick_inc_i   (adj_tick_inc_i),
        .adj_ns_i         (adj_ns_i),
        .adj_sc_i         (adj_sc_i),
        .cfg_intxms_sel_i (cfg_intxms_sel_i),
        .adj_busy_o       (adj_busy_o),
        .adj_done_o       (adj_done_o),
        .bus_addr_o       (bus_addr_o),
        .bus_data_o       (bus_data_o),
        .bus_rd_ce_o      (bus_rd_ce_o),
        .bus_wr_ce_o      (bus_wr_ce_o),
        .bus_rdata_i      (bus_rdata_i)
    );

    always #5 clk = ~clk;

    // Cycle index: strobes issued on the edge after the sample point carry index+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Register-block stand-in: registered read data derived from the address.
    always @(posedge clk or posedge rst) begin
        if (rst) bus_rdata_i <= 32'h0;
        else if (bus_rd_ce_o) bus_rdata_i <= bus_addr_o ^ RD_XOR;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: protocol rules every cycle, and a log of sequencer writes.
    always @(negedge clk) begin
        recT r;
        if (!rst) begin
            checkOutput("oneStrobe", 64'(bus_rd_ce_o & bus_wr_ce_o), 64'd0);
            if (bus_rd_ce_o || bus_wr_ce_o) begin
                if (host_ack_o) begin
                    hostCycQ.push_back(cyc);
                end else begin
                    r.c = cyc; r.a = bus_addr_o; r.d = bus_data_o;
                    seqQ.push_back(r);
                end
            end else begin
                checkOutput("idleBusZero", {bus_addr_o, bus_data_o}, 64'd0);
            end
            if (host_ack_o) checkOutput("ackHasStrobe", 64'(bus_rd_ce_o | bus_wr_ce_o), 64'd1);
        end
    end

    // Reference model: the list of register writes a given mode must produce.
    task automatic buildExp(input logic [2:0] m, input logic [31:0] tick, input logic [31:0] ns,
                            input logic [47:0] sc, input logic intx);
        recT r;
        expQ.delete();
        expHasCtl = 1'b0;
        r.c = 0;
        if (m[2]) begin
            r.a = A_CTL; r.d = {29'h0, intx, 2'b10}; expQ.push_back(r);
            expHasCtl = 1'b1;
        end else begin
            if (m[0]) begin r.a = A_TICK; r.d = tick; expQ.push_back(r); end
            if (m[1]) begin
                r.a = A_NS;  r.d = ns;                   expQ.push_back(r);
                r.a = A_SC0; r.d = sc[47:16];            expQ.push_back(r);
                r.a = A_SC1; r.d = {16'h0, sc[15:0]};    expQ.push_back(r);
                r.a = A_CTL; r.d = {29'h0, intx, 2'b01}; expQ.push_back(r);
                expHasCtl = 1'b1;
            end
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        host_addr_i = 0; host_wdata_i = 0; host_rd_i = 0; host_wr_i = 0;
        adj_req_i = 0; adj_mode_i = 0; adj_tick_inc_i = 0; adj_ns_i = 0; adj_sc_i = 0;
        cfg_intxms_sel_i = 0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusAddr",  bus_addr_o, 0);
        checkOutput("rstBusData",  bus_data_o, 0);
        checkOutput("rstStrobes",  {bus_rd_ce_o, bus_wr_ce_o}, 0);
        checkOutput("rstHost",     {host_ack_o, host_rvld_o}, 0);
        checkOutput("rstRdata",    host_rdata_o, 0);
        checkOutput("rstAdj",      {adj_busy_o, adj_done_o}, 0);
        rst = 1'b0;
    endtask

    // One host access; expAck is the expected latency from request to ack.
    task automatic applyHostStimulus(input bit isRd, input logic [31:0] addr,
                                     input logic [31:0] wdata, input int expAck);
        int s;
        bit seen = 1'b0;
        @(negedge clk);
        host_addr_i = addr; host_wdata_i = wdata;
        host_rd_i = isRd; host_wr_i = !isRd;
        s = cyc;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (host_ack_o) seen = 1'b1;
        end
        checkOutput("hostAckSeen", 64'(seen), 64'd1);
        checkOutput("hostAckLat",  64'(cyc - s), 64'(expAck));
        checkOutput("hostRdCe",    64'(bus_rd_ce_o), 64'(isRd));
        checkOutput("hostWrCe",    64'(bus_wr_ce_o), 64'(!isRd));
        checkOutput("hostAddr",    bus_addr_o, addr);
        checkOutput("hostData",    bus_data_o, isRd ? 32'h0 : wdata);
        host_rd_i = 1'b0; host_wr_i = 1'b0;
        if (isRd) begin
            @(negedge clk);
            checkOutput("hostRvld",  64'(host_rvld_o), 64'd1);
            checkOutput("hostRdata", host_rdata_o, addr ^ RD_XOR);
        end
    endtask

    // One adjustment sequence; delay is how many cycles arbitration should hold it back.
    task automatic applySeqStimulus(input logic [2:0] m, input logic [31:0] tick, input logic [31:0] ns,
                                    input logic [47:0] sc, input logic intx, input int delay);
        int s, first, lastBusy, expDone, n;
        bit seen = 1'b0;
        @(negedge clk);
        seqQ.delete(); hostCycQ.delete();
        adj_mode_i = m; adj_tick_inc_i = tick; adj_ns_i = ns; adj_sc_i = sc;
        cfg_intxms_sel_i = intx; adj_req_i = 1'b1;
        s = cyc;
        buildExp(m, tick, ns, sc, intx);
        n        = expQ.size();
        first    = s + 1 + delay;
        lastBusy = first + n - 1 + (expHasCtl ? HOLD : 0);
        expDone  = lastBusy + 1;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            checkOutput("busy", 64'(adj_busy_o), 64'(cyc >= first && cyc <= lastBusy));
            if (adj_done_o) seen = 1'b1;
        end
        checkOutput("doneSeen",  64'(seen), 64'd1);
        checkOutput("doneCycle", 64'(cyc), 64'(expDone));
        adj_req_i = 1'b0;
        checkOutput("nStrobes", 64'(seqQ.size()), 64'(n));
        for (int i = 0; i < n && i < seqQ.size(); i++) begin
            checkOutput("seqAddr",  seqQ[i].a, expQ[i].a);
            checkOutput("seqData",  seqQ[i].d, expQ[i].d);
            checkOutput("seqCycle", 64'(seqQ[i].c), 64'(first + i));
        end
        foreach (hostCycQ[i]) begin
            checkOutput("hostInterleave", 64'(hostCycQ[i] >= first && hostCycQ[i] < first + n), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        logic [2:0]  m;
        logic [47:0] sc;

        applyReset();

        $display("[TB] directed sequences");
        applySeqStimulus(3'b011, 32'h0640_0000, 32'd500, 48'h1, 1'b0, 0);
        applySeqStimulus(3'b100, $urandom, $urandom, {16'($urandom), 32'($urandom)}, 1'b1, 0);
        applySeqStimulus(3'b000, $urandom, $urandom, {16'($urandom), 32'($urandom)}, 1'b0, 0);

        $display("[TB] random sequences");
        for (int i = 0; i < 16; i++) begin
            m  = 3'($urandom_range(0, 7));
            sc = {16'($urandom), 32'($urandom)};
            applySeqStimulus(m, $urandom, $urandom, sc, 1'($urandom), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] random host accesses");
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyHostStimulus(1'($urandom), $urandom, $urandom, 1);
        end

        // Fresh round-robin pointer favours the host: read first, then the clear burst.
        $display("[TB] simultaneous requests, host preferred");
        applyReset();
        fork
            applyHostStimulus(1'b1, 32'h0000_1008, 32'h0, 1);
            applySeqStimulus(3'b100, 32'h0, 32'h0, 48'h0, 1'b1, 1);
        join

        // One host grant moves the preference to the sequencer. The host then waits
        // through the burst and is served in the second HOLD cycle.
        $display("[TB] simultaneous requests, sequencer preferred");
        applyReset();
        applyHostStimulus(1'b0, 32'h0000_1004, 32'h1234_5678, 1);
        fork
            applyHostStimulus(1'b0, 32'hABCD_0010, 32'hCAFE_F00D, 7);
            applySeqStimulus(3'b011, $urandom, $urandom, {16'($urandom), 32'($urandom)}, 1'b0, 0);
        join

        $display("[TB] reset during burst");
        @(negedge clk);
        adj_mode_i = 3'b011; adj_sc_i = 48'h1234_5678_9ABC; adj_req_i = 1'b1;
        s = cyc;
        while (cyc < s + 3) @(negedge clk);
        checkOutput("preAbortWrCe", 64'(bus_wr_ce_o), 64'd1);
        checkOutput("preAbortAddr", bus_addr_o, A_SC0);
        #1 rst = 1'b1;
        #1;
        checkOutput("abortWrCe", 64'(bus_wr_ce_o), 64'd0);
        checkOutput("abortBusy", 64'(adj_busy_o), 64'd0);
        checkOutput("abortAddr", bus_addr_o, 0);
        adj_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seqQ.delete();
        repeat (12) begin
            @(negedge clk);
            checkOutput("abortNoDone", 64'(adj_done_o), 64'd0);
        end
        checkOutput("abortNoStrobes", 64'(seqQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
